// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - SCAN-order floor request scheduler for one elevator car
// Optional build macro EMERGENCY_FLUSH_EN: drop all pending requests on entry to HALT.
module elevator_request_scheduler #(
   parameter int NUM_FLOORS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Emergency,
   input  logic        call_valid,
   input  logic [3:0]  call_floor,
   output logic        call_ready,
   input  logic [3:0]  current_floor,
   input  logic        door_status,
   output logic [3:0]  floor_request,
   output logic        req_valid,
   output logic [15:0] pending,
   output logic [1:0]  sched_dir
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   state_t      r_state;
   logic [15:0] r_pending;
   logic [3:0]  r_floor_request;
   logic        r_req_valid;

   logic        w_accept;
   logic        w_floor_ok;
   logic        w_served_on_press;
   logic        w_service;
   logic        w_dwell;
   logic [15:0] w_set_mask;
   logic [15:0] w_clr_mask;
   logic [15:0] w_pending_next;
   logic        w_any;
   logic        w_any_ge;
   logic        w_any_le;
   logic [3:0]  w_lo_ge;
   logic [3:0]  w_hi_le;
   state_t      w_sel_state;
   logic        w_sel_valid;
   logic [3:0]  w_sel_floor;

   assign call_ready    = ~Emergency;
   assign pending       = r_pending;
   assign sched_dir     = r_state;
   assign floor_request = r_floor_request;
   assign req_valid     = r_req_valid;

   // A press for the floor where the door is already open counts as served on the spot.
   assign w_accept          = call_valid && !Emergency;
   assign w_floor_ok        = int'(call_floor) < NUM_FLOORS;
   assign w_served_on_press = door_status && (call_floor == current_floor);
   assign w_set_mask        = (w_accept && w_floor_ok && !w_served_on_press) ?
                              (16'd1 << call_floor) : 16'd0;

   assign w_dwell    = r_req_valid && door_status && (current_floor == r_floor_request);
   assign w_service  = w_dwell && !Emergency && (r_state != ST_HALT);
   assign w_clr_mask = w_service ? (16'd1 << r_floor_request) : 16'd0;

`ifdef EMERGENCY_FLUSH_EN
   assign w_pending_next = Emergency ? 16'd0 : ((r_pending | w_set_mask) & ~w_clr_mask);
`else
   assign w_pending_next = (r_pending | w_set_mask) & ~w_clr_mask;
`endif

   always_comb begin
      w_lo_ge  = 4'd0;
      w_any_ge = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (r_pending[i] && (i >= int'(current_floor))) begin
            w_lo_ge  = 4'(i);
            w_any_ge = 1'b1;
         end
      end
      w_hi_le  = 4'd0;
      w_any_le = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (r_pending[i] && (i <= int'(current_floor))) begin
            w_hi_le  = 4'(i);
            w_any_le = 1'b1;
         end
      end
   end

   assign w_any = |r_pending;

   // IDLE and UP share the same preference order: upward first, then reverse.
   always_comb begin
      w_sel_state = ST_IDLE;
      w_sel_valid = 1'b0;
      w_sel_floor = r_floor_request;
      if (r_state == ST_DOWN) begin
         if (w_any_le) begin
            w_sel_state = ST_DOWN;
            w_sel_valid = 1'b1;
            w_sel_floor = w_hi_le;
         end else if (w_any) begin
            w_sel_state = ST_UP;
            w_sel_valid = 1'b1;
            w_sel_floor = w_lo_ge;
         end
      end else begin
         if (w_any_ge) begin
            w_sel_state = ST_UP;
            w_sel_valid = 1'b1;
            w_sel_floor = w_lo_ge;
         end else if (w_any) begin
            w_sel_state = ST_DOWN;
            w_sel_valid = 1'b1;
            w_sel_floor = w_hi_le;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_pending       <= 16'd0;
         r_floor_request <= 4'd0;
         r_req_valid     <= 1'b0;
      end else begin
         r_pending <= w_pending_next;
         if (Emergency) begin
            r_state     <= ST_HALT;
            r_req_valid <= 1'b0;
         end else if (r_state == ST_HALT) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
         end else begin
            // Door dwell at the target freezes the target floor until the door closes.
            r_state     <= w_sel_state;
            r_req_valid <= w_sel_valid;
            if (w_sel_valid && !w_dwell)
               r_floor_request <= w_sel_floor;
         end
      end
   end

endmodule
